alu_op_issue: RTL
=================

# alu_op_issue

Issue stage in front of the core's combinational ALU. Accepts one decoded-register-read RV32I instruction per cycle over a valid/ready handshake. Forms the ALU operands and the 5-bit ALU operation code, and holds them in an output register for the ALU and branch logic. Sits between register-file read and execute, and is the only producer of the ALU's operand and opcode inputs.

## Interface
- No parameters; XLEN fixed at 32.
- `clk_i` in 1: core clock.
- `rst_i` in 1: synchronous, active-high reset.
- `in_valid_i` in 1: upstream instruction valid.
- `in_ready_o` out 1: stage can accept this cycle.
- `instr_i` in 32: raw instruction word.
- `pc_i` in 32: instruction address.
- `rs1_data_i` in 32: rs1 register value.
- `rs2_data_i` in 32: rs2 register value.
- `flush_i` in 1: discard all held and incoming entries.
- `out_valid_o` out 1: held entry valid.
- `out_ready_i` in 1: execute stage consumes the entry.
- `a_o` out 32: ALU operand A.
- `b_o` out 32: ALU operand B.
- `c_o` out 5: ALU operation code.
- `rd_o` out 5: destination register.
- `wb_en_o` out 1: result written back (forced 0 when rd=0).
- `is_branch_o` out 1: conditional branch; ALU result is the taken flag.
- `illegal_o` out 1: unsupported opcode.
- `issue_cnt_o` out 16: entries delivered (`out_valid_o & out_ready_i`), wraps at 0xFFFF to 0.

## Operation
- Opcode map, fixed for the core:
  - add 00000, sll 00001, slt 00010, sltu 00011, xor 00100, srl 00101, or 00110, and 00111.
  - sub 01000, sra 01101.
  - beq 10000, bne 10001, blt 10100, bge 10101, bltu 10110, bgeu 10111.
  - pass-A 11111.
- Per-instruction decode:
  - OP (0110011): A=rs1, B=rs2, c={0, instr[30], funct3}.
  - OP-IMM (0010011): A=rs1, B=sign-extended imm[11:0]. c={0, instr[30] only when funct3=101, funct3}.
  - BRANCH (1100011): A=rs1, B=rs2, c={10, funct3}, is_branch=1, wb_en=0.
  - LUI: A=0, B={imm[31:12], 12'b0}, c=add.
  - AUIPC: A=pc, B=U-immediate, c=add.
  - JAL/JALR: A=pc+4 (mod 2^32), B=0, c=pass-A, wb_en per rd.
  - LOAD: A=rs1, B=I-immediate, c=add.
  - STORE: A=rs1, B=S-immediate, c=add, wb_en=0.
  - Any other opcode, including branch funct3 010 or 011: illegal=1, c=00000, A=B=0, wb_en=0, is_branch=0. The entry is still delivered in order.
- Transfers: input accepted on `in_valid_i & in_ready_o`; output delivered on `out_valid_o & out_ready_i`.
- Entries leave strictly in arrival order. No entry is dropped or duplicated except by flush.
- Flush:
  - All held entries invalidated at the next edge.
  - An input presented in the flush cycle is discarded.
  - `issue_cnt_o` is unaffected.
- Reset has priority over flush.
- Reset values: `out_valid_o`=0, `in_ready_o`=1, `a_o`/`b_o`/`c_o`/`rd_o`=0, `wb_en_o`/`is_branch_o`/`illegal_o`=0, `issue_cnt_o`=0.
- Reset mid-transfer discards all entries.

## Timing
- Latency: input accepted at edge N drives `out_valid_o`=1 from edge N onward (visible in cycle N+1).
- Throughput: 1 instruction/cycle while `out_ready_i`=1.
- All outputs are registered. No combinational path from `instr_i` or operand inputs to any output.
- Accept and deliver in the same cycle is allowed when an entry is held. The occupancy count is then unchanged.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - Two-entry skid buffer (main + skid).
  - `in_ready_o` is registered: 0 only when both entries are full.
  - The skid entry moves to the output when main drains.
  - Empty→full ordering is preserved.
- Undefined:
  - Single output register.
  - `in_ready_o` = `!out_valid_o | out_ready_i` (combinational from `out_ready_i`).
  - All other behaviour identical.

## Test plan
- add x3,x1,x2: instr 0x002081B3, rs1=5, rs2=7 → next cycle out_valid=1, a=5, b=7, c=00000, rd=3, wb_en=1.
- srai x5,x6,3: instr 0x40335293, rs1=0xFFFFFF00 → c=01101, a=0xFFFFFF00, b=0x00000403, wb_en=1.
- beq x1,x2,+8: instr 0x00208463 → c=10000, is_branch=1, wb_en=0, a=rs1, b=rs2.
- Backpressure with SKID_EN: out_ready=0, push 0x002081B3 then 0x40335293 → in_ready=0 after the second accept. Release out_ready → both delivered in order on consecutive cycles, issue_cnt=2.
- Flush with two entries held, plus a third valid input in the flush cycle → out_valid=0 next cycle, none delivered, issue_cnt unchanged, in_ready=1.
- instr 0x0000007F → illegal=1, c=00000, wb_en=0. Also: assert rst_i while out_valid=1 → all outputs at reset values the following cycle.

Source files
------------

// File: rtl/alu_op_issue.sv
// Issue stage in front of the combinational ALU: decodes RV32I operands/opcode into a registered entry.
// Build option ALU_ISSUE_SKID_EN adds a second (skid) entry and a registered in_ready_o.
module alu_op_issue (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [4:0]  c_o,
    output logic [4:0]  rd_o,
    output logic        wb_en_o,
    output logic        is_branch_o,
    output logic        illegal_o,
    output logic [15:0] issue_cnt_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_PASS_A = 5'b11111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  c;
        logic [4:0]  rd;
        logic        wb_en;
        logic        is_branch;
        logic        illegal;
    } entry_t;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [31:0] w_pc_plus4;
    entry_t      w_dec;

    assign w_opcode   = instr_i[6:0];
    assign w_funct3   = instr_i[14:12];
    assign w_rd       = instr_i[11:7];
    assign w_imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_u    = {instr_i[31:12], 12'b0};
    assign w_pc_plus4 = pc_i + 32'd4;

    // Instructions without a destination (branch, store, illegal) report rd=0.
    always_comb begin
        w_dec = '0;
        case (w_opcode)
            OPC_OP: begin
                w_dec.a     = rs1_data_i;
                w_dec.b     = rs2_data_i;
                w_dec.c     = {1'b0, instr_i[30], w_funct3};
                w_dec.rd    = w_rd;
                w_dec.wb_en = (w_rd != 5'd0);
            end
            OPC_OP_IMM: begin
                w_dec.a     = rs1_data_i;
                w_dec.b     = w_imm_i;
                w_dec.c     = {1'b0, (w_funct3 == 3'b101) & instr_i[30], w_funct3};
                w_dec.rd    = w_rd;
                w_dec.wb_en = (w_rd != 5'd0);
            end
            OPC_BRANCH: begin
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
                    w_dec.illegal = 1'b1;
                end else begin
                    w_dec.a         = rs1_data_i;
                    w_dec.b         = rs2_data_i;
                    w_dec.c         = {2'b10, w_funct3};
                    w_dec.is_branch = 1'b1;
                end
            end
            OPC_LUI: begin
                w_dec.b     = w_imm_u;
                w_dec.c     = ALU_ADD;
                w_dec.rd    = w_rd;
                w_dec.wb_en = (w_rd != 5'd0);
            end
            OPC_AUIPC: begin
                w_dec.a     = pc_i;
                w_dec.b     = w_imm_u;
                w_dec.c     = ALU_ADD;
                w_dec.rd    = w_rd;
                w_dec.wb_en = (w_rd != 5'd0);
            end
            OPC_JAL, OPC_JALR: begin
                w_dec.a     = w_pc_plus4;
                w_dec.c     = ALU_PASS_A;
                w_dec.rd    = w_rd;
                w_dec.wb_en = (w_rd != 5'd0);
            end
            OPC_LOAD: begin
                w_dec.a     = rs1_data_i;
                w_dec.b     = w_imm_i;
                w_dec.c     = ALU_ADD;
                w_dec.rd    = w_rd;
                w_dec.wb_en = (w_rd != 5'd0);
            end
            OPC_STORE: begin
                w_dec.a = rs1_data_i;
                w_dec.b = w_imm_s;
                w_dec.c = ALU_ADD;
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    // Handshake: a beat moves on an edge where valid & ready are both high; valid never
    // waits on ready. An input beat in a flush cycle is dropped rather than accepted.
    entry_t r_main;
    logic   r_main_valid;
    logic   w_accept;
    logic   w_deliver;

    assign w_accept  = in_valid_i & in_ready_o & ~flush_i;
    assign w_deliver = r_main_valid & out_ready_i;

`ifdef ALU_ISSUE_SKID_EN
    entry_t r_skid;
    logic   r_skid_valid;
    logic   r_in_ready;
    logic   w_main_valid_n;
    logic   w_skid_valid_n;

    always_comb begin
        w_main_valid_n = r_main_valid;
        w_skid_valid_n = r_skid_valid;
        if (w_deliver) begin
            if (r_skid_valid) begin
                w_main_valid_n = 1'b1;
                w_skid_valid_n = w_accept;
            end else begin
                w_main_valid_n = w_accept;
                w_skid_valid_n = 1'b0;
            end
        end else if (w_accept) begin
            if (r_main_valid) begin
                w_skid_valid_n = 1'b1;
            end else begin
                w_main_valid_n = 1'b1;
            end
        end
    end

    // The skid entry always holds the younger instruction, so it refills main on drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_n;
            r_skid_valid <= w_skid_valid_n;
            r_in_ready   <= ~(w_main_valid_n & w_skid_valid_n);
            if (w_deliver && r_skid_valid) begin
                r_main <= r_skid;
            end else if (w_accept && (!r_main_valid || w_deliver)) begin
                r_main <= w_dec;
            end
            if (w_accept && ((r_main_valid && !w_deliver) || (w_deliver && r_skid_valid))) begin
                r_skid <= w_dec;
            end
        end
    end

    assign in_ready_o = r_in_ready;
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main       <= w_dec;
            r_main_valid <= 1'b1;
        end else if (w_deliver) begin
            r_main_valid <= 1'b0;
        end
    end

    assign in_ready_o = ~r_main_valid | out_ready_i;
`endif

    logic [15:0] r_issue_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_issue_cnt <= 16'd0;
        end else if (w_deliver) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign out_valid_o = r_main_valid;
    assign a_o         = r_main.a;
    assign b_o         = r_main.b;
    assign c_o         = r_main.c;
    assign rd_o        = r_main.rd;
    assign wb_en_o     = r_main.wb_en;
    assign is_branch_o = r_main.is_branch;
    assign illegal_o   = r_main.illegal;
    assign issue_cnt_o = r_issue_cnt;

endmodule
